// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Holds the mult/div state encoding, default latencies and the stage-control bundle.
package pipeline_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 33;

  typedef enum logic [2:0] {
    MODE_RUN,
    MODE_FETCH_WAIT,
    MODE_INTERLOCK,
    MODE_REDIRECT,
    MODE_FREEZE
  } ctrl_mode_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  // Translate a resolved scheduling mode into the per-stage enable/flush bundle.
  function automatic stage_ctrl_t mode_to_ctrl(input ctrl_mode_t mode);
    stage_ctrl_t c;
    c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
          mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
    case (mode)
      MODE_FREEZE: begin
        c = '0;
      end
      MODE_REDIRECT: begin
        c.if_id_flush = 1'b1;
        c.id_ex_flush = 1'b1;
      end
      MODE_INTERLOCK: begin
        c.pc_en       = 1'b0;
        c.if_id_en    = 1'b0;
        c.id_ex_flush = 1'b1;
      end
      MODE_FETCH_WAIT: begin
        c.pc_en       = 1'b0;
        c.if_id_flush = 1'b1;
      end
      default: begin
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Request/control bundle between the hazard sources, the stall scheduler and the pipeline registers.
interface pipeline_stall_ctrl_if;

  logic load_use_stall;
  logic branch_taken;
  logic imem_ready;
  logic dmem_ready;
  logic md_start;
  logic md_is_div;
  logic md_read;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic md_busy;
  logic md_done;

  modport master (
    output load_use_stall, branch_taken, imem_ready, dmem_ready,
           md_start, md_is_div, md_read,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, md_busy, md_done
  );

  modport slave (
    input  load_use_stall, branch_taken, imem_ready, dmem_ready,
           md_start, md_is_div, md_read,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, md_busy, md_done
  );

endinterface

// File: rtl/pipeline_stall_ctrl_md_occupancy_counter.sv
// Mult/div occupancy tracker: counts down the unit latency and pulses done when HI/LO are valid.
module md_occupancy_counter
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             done_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
    end
  end

  // A new issue always wins, even on the edge that would have completed the previous op.
  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    if (issue) begin
      state_next = MD_BUSY;
      count_next = is_div ? DIV_LOAD : MULT_LOAD;
    end else if (state == MD_BUSY) begin
      if (count == CNT_W'(1)) begin
        state_next = MD_IDLE;
        count_next = '0;
        done_next  = 1'b1;
      end else begin
        count_next = count - CNT_W'(1);
      end
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: priority-resolves hazard requests
// into stage enables/flushes, tracks mult/div occupancy and counts PC-stall cycles.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus,
  output logic [PERF_W-1:0]    stall_cycles
);

  ctrl_mode_t  mode;
  stage_ctrl_t ctrl;
  logic        md_busy;
  logic        md_done;
  logic        md_issue;

  // Highest-priority condition wins; reset forces RUN so the pipe fills with NOPs.
  always_comb begin
    mode = MODE_RUN;
    if (!rst_n) begin
      mode = MODE_RUN;
    end else if (!bus.dmem_ready) begin
      mode = MODE_FREEZE;
    end else if (bus.branch_taken) begin
      mode = MODE_REDIRECT;
    end else if (bus.load_use_stall || (bus.md_read && md_busy)) begin
      mode = MODE_INTERLOCK;
    end else if (!bus.imem_ready) begin
      mode = MODE_FETCH_WAIT;
    end
  end

  assign ctrl = mode_to_ctrl(mode);

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.if_id_en    = ctrl.if_id_en;
  assign bus.id_ex_en    = ctrl.id_ex_en;
  assign bus.ex_mem_en   = ctrl.ex_mem_en;
  assign bus.mem_wb_en   = ctrl.mem_wb_en;
  assign bus.if_id_flush = ctrl.if_id_flush;
  assign bus.id_ex_flush = ctrl.id_ex_flush;

  // The op only counts as issued once it actually leaves EX.
  assign md_issue = bus.md_start && ctrl.ex_mem_en;

  md_occupancy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .issue  (md_issue),
    .is_div (bus.md_is_div),
    .busy   (md_busy),
    .done   (md_done)
  );

  assign bus.md_busy = md_busy;
  assign bus.md_done = md_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!ctrl.pc_en && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
